// File: rtl/mskaes_128bits_isr_deser.sv
// Byte-serial loader for a d-share AES state that lands every byte directly in its
// InvShiftRows slot, so the parallel round logic sees the already-unshifted state.

module mskaes_isr_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_q <= '0;
    else if (we_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

module mskaes_128bits_isr_deser #(
  parameter int D = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8*D-1:0]   sh_byte_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*D-1:0] sh_state_out
);
  typedef enum logic {S_LOAD, S_FULL} state_e;

  state_e                  state_q;
  logic   [3:0]            cnt_q;
  logic                    in_ready_q, out_valid_q;
  logic   [15:0][8*D-1:0]  buf_q;
  logic   [1:0]            wcol;
  logic   [3:0]            wpos;
  logic                    accept;

  // Input byte k = (column c', row r) goes to column (c'+r) mod 4 of the same row.
  assign wcol   = cnt_q[3:2] + cnt_q[1:0];
  assign wpos   = {wcol, cnt_q[1:0]};
  assign accept = in_valid & in_ready_q & ~abort;

  for (genvar i = 0; i < 16; i++) begin : g_slot
    mskaes_isr_slot #(.W(8*D)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (accept && (wpos == 4'(i))),
      .d_i   (sh_byte_in),
      .q_o   (buf_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (abort) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: if (in_valid) begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q     <= S_FULL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_FULL: if (out_ready) begin
          state_q     <= S_LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign sh_state_out = buf_q;
endmodule

// File: tb/tb_mskaes_128bits_isr_deser.sv
// Drives a 2-share and a 3-share instance in lockstep and checks them against
// a ShiftRows / InvShiftRows model built from the row-rotation definition.

module tb_mskaes_128bits_isr_deser;
  typedef logic [15:0][23:0] st3_t;
  typedef logic [15:0][15:0] st2_t;
  typedef struct { logic [7:0] in_s0; logic [7:0] exp_s0; } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, abort, in_valid, out_ready;
  logic [23:0]  d3;
  logic         irdy2, irdy3, ovld2, ovld3;
  logic [255:0] st2;
  logic [383:0] st3;
  int           npass = 0, ntot = 0;
  vec_t         vec [16];

  always #5 clk = ~clk;

  mskaes_128bits_isr_deser #(.D(2)) u2 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(irdy2),
    .sh_byte_in(d3[15:0]), .out_valid(ovld2), .out_ready(out_ready), .sh_state_out(st2));
  mskaes_128bits_isr_deser #(.D(3)) u3 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(irdy3),
    .sh_byte_in(d3), .out_valid(ovld3), .out_ready(out_ready), .sh_state_out(st3));

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Row r rotated left by r for ShiftRows, right by r for the inverse.
  function automatic st3_t fwd_sr(input st3_t s);
    st3_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[4*c+r] = s[4*((c+r)%4)+r];
    return o;
  endfunction

  function automatic st3_t inv_sr(input st3_t s);
    st3_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[4*c+r] = s[4*((c-r+4)%4)+r];
    return o;
  endfunction

  function automatic st2_t lo2(input st3_t s);
    st2_t o;
    for (int i = 0; i < 16; i++) o[i] = s[i][15:0];
    return o;
  endfunction

  function automatic st3_t rnd_state();
    st3_t s;
    for (int i = 0; i < 16; i++) s[i] = 24'($urandom);
    return s;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [23:0] b);
    int n = 0;
    in_valid = 1'b1; d3 = b;
    while (!irdy3 && n < 200) begin tick; n++; end
    if (n >= 200) chk("push_timeout", 384'(irdy3), 384'd1);
    tick;
    in_valid = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 one idle cycle between bytes, 2 random 0..2 idle cycles
  task automatic send(input st3_t s, input int gap);
    for (int k = 0; k < 16; k++) begin
      push(s[k]);
      if (k < 15) begin
        int g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int j = 0; j < g; j++) begin d3 = 24'($urandom); tick; end
      end
    end
  endtask

  task automatic chk_state(input string nm, input st3_t e);
    chk({nm, "_d3"}, st3, e);
    chk({nm, "_d2"}, 384'(st2), 384'(lo2(e)));
  endtask

  task automatic chk_hs(input string nm, input logic ov, input logic ir);
    chk({nm, "_ovld"}, 384'({ovld3, ovld2}), 384'({ov, ov}));
    chk({nm, "_irdy"}, 384'({irdy3, irdy2}), 384'({ir, ir}));
  endtask

  task automatic chk_table(input string nm);
    for (int p = 0; p < 16; p++)
      chk($sformatf("%s_byte%0d", nm, p), 384'(st2[16*p +: 16]), 384'({8'hA5, vec[p].exp_s0}));
  endtask

  initial begin
    logic [7:0] exp_l [16];
    st3_t s1, s, sab;
    exp_l = '{8'd0, 8'd13, 8'd10, 8'd7, 8'd4, 8'd1, 8'd14, 8'd11,
              8'd8, 8'd5, 8'd2, 8'd15, 8'd12, 8'd9, 8'd6, 8'd3};
    for (int k = 0; k < 16; k++) vec[k] = '{in_s0: 8'(k), exp_s0: exp_l[k]};
    for (int k = 0; k < 16; k++) s1[k] = {8'h3C, 8'hA5, vec[k].in_s0};

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1; d3 = '0;
    #12;
    chk_hs("reset", 1'b0, 1'b1);
    chk_state("reset", '0);
    rst_n = 1'b1;
    tick;

    // back-to-back single block
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk_hs("s1_pre16", 1'b0, 1'b1);
      push(s1[k]);
    end
    chk_hs("s1_full", 1'b1, 1'b0);
    chk_table("s1");
    chk_state("s1", inv_sr(s1));
    tick;
    chk_hs("s1_onecycle", 1'b0, 1'b1);

    // backpressure with junk on the input that must not land
    out_ready = 1'b0;
    s = rnd_state();
    send(s, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; d3 = 24'($urandom);
      tick;
      chk_hs("bp_hold", 1'b1, 1'b0);
      chk("bp_state", st3, inv_sr(s));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    chk_hs("bp_release", 1'b0, 1'b1);
    s = rnd_state();
    send(s, 0);
    chk_state("bp_next", inv_sr(s));
    tick;

    // gapped input
    send(s1, 1);
    chk_hs("gap_full", 1'b1, 1'b0);
    chk_table("gap");
    tick;

    // abort after 7 bytes, with a valid byte in the abort cycle
    for (int k = 0; k < 7; k++) push(24'($urandom));
    abort = 1'b1; in_valid = 1'b1; d3 = 24'hDEAD01;
    tick;
    abort = 1'b0; in_valid = 1'b0;
    chk_hs("abort_load", 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) sab[k] = {8'h5A ^ 8'(k), 8'hC0 + 8'(k), 8'h30 + 8'(k)};
    out_ready = 1'b0;
    send(sab, 0);
    chk_state("abort_blk", inv_sr(sab));
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk_hs("abort_full", 1'b0, 1'b1);
    chk("abort_keep", st3, inv_sr(sab));

    // async reset while FULL
    s = rnd_state();
    send(s, 0);
    chk_hs("ar_pre", 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_hs("ar_async", 1'b0, 1'b1);
    chk_state("ar_async", '0);
    #2 rst_n = 1'b1;
    tick;

    // async reset mid-load; the next block must start at index 0
    for (int k = 0; k < 5; k++) push(24'($urandom));
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick;
    out_ready = 1'b1;

    // round trip through forward ShiftRows
    for (int t = 0; t < 200; t++) begin
      s = rnd_state();
      send(fwd_sr(s), 2);
      chk_state($sformatf("rt%0d", t), s);
      tick;
    end
    chk_hs("rt_end", 1'b0, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
